// File: rtl/game_controller.sv
// game_controller: whack-a-box game sequencer.
// Runs the lobby -> play -> game-over flow, picks pseudo-random targets,
// scores strikes reported by the sensor decoder, and drives the VGA level
// select plus the hit and lobby sound enables.
// Optional build macro GAME_WRONG_HIT_PENALTY_EN: when defined, striking the
// wrong box while armed costs one point (saturating at zero).
module game_controller #(
  parameter int TICK_DIV       = 50_000_000,
  parameter int GAME_SECONDS   = 60,
  parameter int TARGET_SECONDS = 3,
  parameter int NUM_BOXES      = 6,
  parameter int SOUND_CYCLES   = 5_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start_game,
  input  logic [2:0] box_address,
  output logic [2:0] level_select,
  output logic       play_sound,
  output logic       lobby_sound,
  output logic [7:0] score,
  output logic [6:0] time_left,
  output logic       game_over,
  output logic [2:0] state
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SHOW_W = (SOUND_CYCLES > 1) ? $clog2(SOUND_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPAWN    = 3'd1,
    ST_WAIT_HIT = 3'd2,
    ST_HIT_SHOW = 3'd3,
    ST_OVER     = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                r_startPrev;
  logic                r_armed;
  logic [7:0]          r_lfsr;
  logic [2:0]          r_target;
  logic [2:0]          w_nextTarget;
  logic [TICK_W-1:0]   r_tickCnt;
  logic [3:0]          r_targetTicks;
  logic [3:0]          w_nextTargetTicks;
  logic [SHOW_W-1:0]   r_showCnt;
  logic [SHOW_W-1:0]   w_nextShowCnt;
  logic [7:0]          r_score;
  logic [7:0]          w_nextScore;
  logic [6:0]          r_timeLeft;
  logic [6:0]          w_nextTimeLeft;
  logic [2:0]          r_levelSelect;
  logic [2:0]          w_nextLevel;
  logic                r_playSound;
  logic                r_lobbySound;
  logic                r_gameOver;

  logic                w_tick;
  logic                w_startRise;
  logic                w_inPlay;
  logic                w_expire;
  logic                w_hit;
  logic                w_lfsrFb;
  logic [2:0]          w_candidate;
  logic [2:0]          w_bumped;
  logic [2:0]          w_spawnTarget;
`ifdef GAME_WRONG_HIT_PENALTY_EN
  logic                w_wrong;
`endif

  assign w_tick      = (r_tickCnt == TICK_W'(TICK_DIV - 1));
  assign w_startRise = start_game & ~r_startPrev;
  assign w_inPlay    = (r_state == ST_SPAWN) || (r_state == ST_WAIT_HIT) ||
                       (r_state == ST_HIT_SHOW);
  // The game ends on the tick that takes the clock from 1 to 0.
  assign w_expire    = w_inPlay && w_tick && (r_timeLeft == 7'd1);
  assign w_hit       = (r_state == ST_WAIT_HIT) && r_armed &&
                       (box_address == r_target);
`ifdef GAME_WRONG_HIT_PENALTY_EN
  assign w_wrong     = (r_state == ST_WAIT_HIT) && r_armed &&
                       (box_address != 3'd0) && (box_address != r_target);
`endif

  assign w_lfsrFb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  // A fresh target never repeats the previous one; on a repeat step to the next box.
  assign w_candidate   = 3'(r_lfsr % 8'(NUM_BOXES)) + 3'd1;
  assign w_bumped      = (w_candidate == 3'(NUM_BOXES)) ? 3'd1 : (w_candidate + 3'd1);
  assign w_spawnTarget = (w_candidate == r_target) ? w_bumped : w_candidate;

  // Free-running second tick, LFSR, start edge history and strike arming.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_tickCnt   <= '0;
      r_lfsr      <= 8'h01;
      r_startPrev <= 1'b0;
      r_armed     <= 1'b1;
    end else begin
      r_tickCnt   <= w_tick ? '0 : (r_tickCnt + TICK_W'(1));
      r_lfsr      <= {r_lfsr[6:0], w_lfsrFb};
      r_startPrev <= start_game;
      r_armed     <= (box_address == 3'd0);
    end
  end

  // Next-state, score, timers and target selection.
  always_comb begin
    w_nextState       = r_state;
    w_nextScore       = r_score;
    w_nextTimeLeft    = r_timeLeft;
    w_nextTarget      = r_target;
    w_nextTargetTicks = r_targetTicks;
    w_nextShowCnt     = r_showCnt;
    w_nextLevel       = 3'd0;

    if (w_inPlay && w_tick && (r_timeLeft != 7'd0)) begin
      w_nextTimeLeft = r_timeLeft - 7'd1;
    end

    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (w_startRise) begin
          w_nextState    = ST_SPAWN;
          w_nextScore    = 8'd0;
          w_nextTimeLeft = 7'(GAME_SECONDS);
        end
      end
      ST_SPAWN: begin
        w_nextTarget      = w_spawnTarget;
        w_nextTargetTicks = 4'd0;
        w_nextState       = w_expire ? ST_OVER : ST_WAIT_HIT;
      end
      ST_WAIT_HIT: begin
        if (w_expire) begin
          w_nextState = ST_OVER;
        end else if (w_hit) begin
          w_nextScore   = (r_score == 8'hFF) ? r_score : (r_score + 8'd1);
          w_nextShowCnt = '0;
          w_nextState   = ST_HIT_SHOW;
`ifdef GAME_WRONG_HIT_PENALTY_EN
        end else if (w_wrong) begin
          w_nextScore = (r_score == 8'd0) ? r_score : (r_score - 8'd1);
`endif
        end else if (w_tick) begin
          if (r_targetTicks == 4'(TARGET_SECONDS - 1)) begin
            w_nextState = ST_SPAWN;
          end else begin
            w_nextTargetTicks = r_targetTicks + 4'd1;
          end
        end
      end
      ST_HIT_SHOW: begin
        if (w_expire) begin
          w_nextState = ST_OVER;
        end else if (r_showCnt == SHOW_W'(SOUND_CYCLES - 1)) begin
          w_nextState = ST_SPAWN;
        end else begin
          w_nextShowCnt = r_showCnt + SHOW_W'(1);
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase

    case (w_nextState)
      ST_IDLE: w_nextLevel = 3'd0;
      ST_OVER: w_nextLevel = 3'd7;
      default: w_nextLevel = w_nextTarget;
    endcase
  end

  // State register and game datapath.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_score       <= 8'd0;
      r_timeLeft    <= 7'(GAME_SECONDS);
      r_target      <= 3'd1;
      r_targetTicks <= 4'd0;
      r_showCnt     <= '0;
    end else begin
      r_state       <= w_nextState;
      r_score       <= w_nextScore;
      r_timeLeft    <= w_nextTimeLeft;
      r_target      <= w_nextTarget;
      r_targetTicks <= w_nextTargetTicks;
      r_showCnt     <= w_nextShowCnt;
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_levelSelect <= 3'd0;
      r_playSound   <= 1'b0;
      r_lobbySound  <= 1'b1;
      r_gameOver    <= 1'b0;
    end else begin
      r_levelSelect <= w_nextLevel;
      r_playSound   <= (w_nextState == ST_HIT_SHOW);
      r_lobbySound  <= (w_nextState == ST_IDLE);
      r_gameOver    <= (w_nextState == ST_OVER);
    end
  end

  assign level_select = r_levelSelect;
  assign play_sound   = r_playSound;
  assign lobby_sound  = r_lobbySound;
  assign score        = r_score;
  assign time_left    = r_timeLeft;
  assign game_over    = r_gameOver;
  assign state        = r_state;

endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: randomized bench for game_controller with a
// behavioural game model driven by absolute cycle counts.
module tb_game_controller;

  localparam int TD = 16;
  localparam int GS = 127;
  localparam int TS = 2;
  localparam int NB = 6;
  localparam int SC = 3;

  localparam int P_LOBBY = 0;
  localparam int P_SPAWN = 1;
  localparam int P_AWAIT = 2;
  localparam int P_SHOW  = 3;
  localparam int P_END   = 4;

  logic       CLOCK_50;
  logic       reset;
  logic       start_game;
  logic [2:0] box_address;
  logic [2:0] level_select;
  logic       play_sound;
  logic       lobby_sound;
  logic [7:0] score;
  logic [6:0] time_left;
  logic       game_over;
  logic [2:0] state;

  int checkCount;
  int errorCount;

  // Behavioural game model
  int         edgeCount;
  int         mPhase;
  int         mScore;
  int         mTime;
  int         mTarget;
  int         mTargetSecs;
  int         mShowLeft;
  bit         mArmed;
  bit         mPrevStart;
  logic [7:0] mLfsr;

  game_controller #(
    .TICK_DIV(TD), .GAME_SECONDS(GS), .TARGET_SECONDS(TS),
    .NUM_BOXES(NB), .SOUND_CYCLES(SC)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start_game(start_game),
    .box_address(box_address), .level_select(level_select),
    .play_sound(play_sound), .lobby_sound(lobby_sound), .score(score),
    .time_left(time_left), .game_over(game_over), .state(state)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    edgeCount   = 0;
    mPhase      = P_LOBBY;
    mScore      = 0;
    mTime       = GS;
    mTarget     = 1;
    mTargetSecs = 0;
    mShowLeft   = 0;
    mArmed      = 1'b1;
    mPrevStart  = 1'b0;
    mLfsr       = 8'h01;
  endtask

  task automatic modelStep(input logic st, input logic [2:0] box);
    bit tick, rise, inPlay, expire, strike;
    int nt;
    edgeCount++;
    tick   = (edgeCount % TD) == 0;
    rise   = st && !mPrevStart;
    inPlay = (mPhase == P_SPAWN) || (mPhase == P_AWAIT) || (mPhase == P_SHOW);
    expire = inPlay && tick && (mTime == 1);
    strike = mArmed && (box != 3'd0);
    if (inPlay && tick && mTime > 0) mTime--;
    case (mPhase)
      P_LOBBY, P_END: begin
        if (rise) begin
          mPhase = P_SPAWN;
          mScore = 0;
          mTime  = GS;
        end
      end
      P_SPAWN: begin
        nt = (int'(mLfsr) % NB) + 1;
        if (nt == mTarget) nt = (nt % NB) + 1;
        mTarget     = nt;
        mTargetSecs = 0;
        mPhase      = expire ? P_END : P_AWAIT;
      end
      P_AWAIT: begin
        if (expire) begin
          mPhase = P_END;
        end else if (strike && int'(box) == mTarget) begin
          mScore    = (mScore < 255) ? mScore + 1 : 255;
          mShowLeft = SC;
          mPhase    = P_SHOW;
`ifdef GAME_WRONG_HIT_PENALTY_EN
        end else if (strike) begin
          if (mScore > 0) mScore--;
`endif
        end else if (tick) begin
          mTargetSecs++;
          if (mTargetSecs == TS) mPhase = P_SPAWN;
        end
      end
      P_SHOW: begin
        if (expire) begin
          mPhase = P_END;
        end else begin
          mShowLeft--;
          if (mShowLeft == 0) mPhase = P_SPAWN;
        end
      end
      default: mPhase = P_LOBBY;
    endcase
    mArmed     = (box == 3'd0);
    mPrevStart = st;
    mLfsr      = {mLfsr[6:0], ^(mLfsr & 8'hB8)};
  endtask

  task automatic checkModel();
    int expLevel;
    expLevel = (mPhase == P_LOBBY) ? 0 : (mPhase == P_END) ? 7 : mTarget;
    checkOutput("state", state, mPhase);
    checkOutput("level_select", level_select, expLevel);
    checkOutput("play_sound", play_sound, mPhase == P_SHOW);
    checkOutput("lobby_sound", lobby_sound, mPhase == P_LOBBY);
    checkOutput("game_over", game_over, mPhase == P_END);
    checkOutput("score", score, mScore);
    checkOutput("time_left", time_left, mTime);
  endtask

  task automatic applyStimulus(input logic st, input logic [2:0] box);
    start_game  = st;
    box_address = box;
    @(posedge CLOCK_50);
    modelStep(st, box);
    @(negedge CLOCK_50);
    checkModel();
  endtask

  task automatic doReset();
    reset       = 1'b1;
    start_game  = 1'b0;
    box_address = 3'd0;
    @(posedge CLOCK_50);
    modelReset();
    @(negedge CLOCK_50);
    reset = 1'b0;
    checkModel();
  endtask

  task automatic waitAwait();
    int n;
    n = 0;
    while (mPhase != P_AWAIT && n < 100) begin
      applyStimulus(1'b0, 3'd0);
      n++;
    end
    if (n >= 100) checkOutput("awaitTimeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles, lastTarget, oldT, wrongBox, soundCycles, expScore;
    logic [2:0] prevState;
    checkCount  = 0;
    errorCount  = 0;
    reset       = 1'b1;
    start_game  = 1'b0;
    box_address = 3'd0;

    // Idle lobby with sensor noise
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 3'($urandom_range(0, 7)));
    checkOutput("idleLevel", level_select, 0);
    checkOutput("idleLobby", lobby_sound, 1);
    checkOutput("idleScore", score, 0);
    checkOutput("idleSound", play_sound, 0);

    // Start and never strike: targets cycle and the game runs out
    applyStimulus(1'b1, 3'd0);
    lastTarget = 1;
    prevState  = state;
    cycles     = 0;
    while (!game_over && cycles < 3000) begin
      applyStimulus(1'b0, 3'd0);
      cycles++;
      if (state == 3'd2 && prevState != 3'd2) begin
        checkOutput("targetChanged", level_select != 3'(lastTarget), 1);
        checkOutput("targetRange", (level_select >= 3'd1) && (level_select <= 3'(NB)), 1);
        lastTarget = int'(level_select);
      end
      prevState = state;
    end
    checkOutput("overWindow",
                (cycles >= (GS - 1) * TD + 1) && (cycles <= GS * TD), 1);
    checkOutput("overLevel", level_select, 7);
    checkOutput("overFlag", game_over, 1);

    // Restart from game over; wrong box at score zero
    applyStimulus(1'b1, 3'd0);
    applyStimulus(1'b0, 3'd0);
    waitAwait();
    wrongBox = (mTarget % NB) + 1;
    applyStimulus(1'b0, 3'(wrongBox));
    applyStimulus(1'b0, 3'd0);
    checkOutput("wrongAtZero", score, 0);

    // One long strike scores once with a single sound pulse
    waitAwait();
    oldT = mTarget;
    soundCycles = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 3'(oldT));
      if (play_sound) soundCycles++;
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 3'd0);
      if (play_sound) soundCycles++;
    end
    checkOutput("soundLen", soundCycles, SC);
    checkOutput("scoreOnce", score, 1);
    checkOutput("hitNewTarget", (state == 3'd2) && (level_select != 3'(oldT)), 1);

    // Wrong box after a hit
    waitAwait();
    wrongBox = (mTarget % NB) + 1;
    applyStimulus(1'b0, 3'(wrongBox));
    applyStimulus(1'b0, 3'd0);
`ifdef GAME_WRONG_HIT_PENALTY_EN
    expScore = 0;
`else
    expScore = 1;
`endif
    checkOutput("wrongAfterHit", score, expScore);

    // Reset in the middle of the hit display
    waitAwait();
    applyStimulus(1'b0, 3'(mTarget));
    checkOutput("inShow", state, 3);
    applyStimulus(1'b0, 3'd0);
    doReset();
    checkOutput("rstState", state, 0);
    checkOutput("rstSound", play_sound, 0);
    checkOutput("rstScore", score, 0);
    checkOutput("rstTime", time_left, GS);
    checkOutput("rstLevel", level_select, 0);

    // Randomized play with occasional starts and mixed strikes
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [2:0] b;
      r = $urandom_range(0, 99);
      if (r < 40)      b = 3'd0;
      else if (r < 70) b = 3'(mTarget);
      else             b = 3'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 99) < 2, b);
    end

    // Score saturation
    doReset();
    applyStimulus(1'b1, 3'd0);
    applyStimulus(1'b0, 3'd0);
    for (int h = 0; h < 256; h++) begin
      waitAwait();
      applyStimulus(1'b0, 3'(mTarget));
      applyStimulus(1'b0, 3'd0);
      if (h == 254) checkOutput("score255", score, 255);
    end
    checkOutput("scoreHold", score, 255);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/game_controller.md
# game_controller

Game sequencer for the whack-a-box datapath. Owns the lobby/play/game-over flow, picks pseudo-random target boxes, and compares the sensor box address against the live target. It also keeps score and the game countdown, and drives the VGA level-select, the hit sound and the lobby sound. It sits between the sensor decoder (`box_address`) and the VGA fill/audio units, replacing direct switch control of `level_select`.

## Interface
- `TICK_DIV`, 50_000_000: CLOCK_50 cycles per one-second tick.
- `GAME_SECONDS`, 60: game length in seconds (1..127).
- `TARGET_SECONDS`, 3: seconds a target stays live before counting as a miss (1..15).
- `NUM_BOXES`, 6: number of physical boxes; targets are 1..NUM_BOXES (2..6).
- `SOUND_CYCLES`, 5_000_000: length of the `play_sound` pulse, and of the HIT_SHOW hold.

- `CLOCK_50`, in, 1: sole clock.
- `reset`, in, 1: synchronous, active-high.
- `start_game`, in, 1: level input, rising-edge detected internally.
- `box_address`, in, 3: struck box from the sensor decoder. 0 means no strike.
- `level_select`, out, 3: screen select to fill. 0 is lobby, 1..6 is target box, 7 is game over.
- `play_sound`, out, 1: hit sound enable to audio_main.
- `lobby_sound`, out, 1: high while in IDLE.
- `score`, out, 8: current score.
- `time_left`, out, 7: seconds remaining.
- `game_over`, out, 1: high in OVER.
- `state`, out, 3: FSM state code for debug.

## Operation
- State codes: IDLE=0, SPAWN=1, WAIT_HIT=2, HIT_SHOW=3, OVER=4.
- IDLE:
  - Outputs: `level_select`=0, `lobby_sound`=1.
  - A `start_game` rising edge moves to SPAWN, clears `score`, and loads `time_left`=GAME_SECONDS.
- SPAWN (exactly 1 cycle):
  - Loads `target` = (lfsr mod NUM_BOXES)+1.
  - If that equals the previous target, uses (target mod NUM_BOXES)+1 instead.
  - Clears the per-target second counter, then goes to WAIT_HIT.
- WAIT_HIT:
  - `level_select`=target.
  - Hit: `box_address`==target while armed. Score +1, saturating at 255. Assert `play_sound`. Go to HIT_SHOW.
  - Wrong box: `box_address`≠0, ≠target, while armed. See Configuration.
  - Timeout: TARGET_SECONDS ticks elapse with no hit. Counts as a miss, no score change, back to SPAWN.
- Arming:
  - The armed flag clears on any nonzero `box_address` sample.
  - It re-arms only after `box_address` is sampled 0.
  - One continuous strike therefore scores at most once.
- HIT_SHOW:
  - `level_select` holds target.
  - Stays SOUND_CYCLES cycles, then goes to SPAWN.
- OVER:
  - `level_select`=7, `game_over`=1, score frozen.
  - A `start_game` rising edge restarts the game directly (SPAWN, score cleared, timer reloaded).
- Game timer:
  - Runs in SPAWN, WAIT_HIT and HIT_SHOW.
  - Each tick decrements `time_left`.
  - When `time_left` reaches 0, goes to OVER from any play state.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Seed 8'h01 on reset; advances every cycle, including IDLE.
- Priority within one cycle: reset > game timer expiry > hit/wrong hit > target timeout.
- A hit coinciding with timer expiry is not scored.

## Timing
- Reset values:
  - state=IDLE, `level_select`=0, `lobby_sound`=1.
  - `play_sound`=0, `score`=0, `time_left`=GAME_SECONDS, `game_over`=0.
  - target=1, armed=1, lfsr=8'h01.
- All outputs are registered.
- start_game:
  - Edge at input in cycle N gives SPAWN at N+1 and WAIT_HIT at N+2.
  - `level_select` shows the target from N+2.
- Hit:
  - `box_address` match sampled at N gives `score` updated, `play_sound`=1 and HIT_SHOW at N+1.
  - `play_sound` stays high exactly SOUND_CYCLES cycles, then falls.
  - SPAWN follows at N+1+SOUND_CYCLES.
- Tick counter: free-running modulo TICK_DIV, started at reset, producing a 1-cycle tick.
- Target timer: counts ticks only in WAIT_HIT. Timeout fires on the cycle of the TARGET_SECONDS-th tick.
- Reset mid-game: at the next edge all state returns to reset values and any sound pulse is aborted.

## Configuration
- `GAME_WRONG_HIT_PENALTY_EN` defined: a wrong-box strike in WAIT_HIT decrements `score`, saturating at 0. State stays WAIT_HIT and the target is unchanged.
- Not defined: wrong-box strikes only clear `armed`. Score is unaffected.

## Test plan
- Reset, then hold idle 20 cycles: `level_select`=0, `lobby_sound`=1, `score`=0, `play_sound`=0.
- TICK_DIV=4, GAME_SECONDS=5. Start, then never strike:
  - Each TARGET_SECONDS×4 cycles a new target appears, differing from the previous one.
  - At 20 cycles after start: `game_over`=1, `level_select`=7.
- Start, then drive `box_address`=target for 10 cycles:
  - `score`=1, once only.
  - `play_sound` high exactly SOUND_CYCLES cycles.
  - A new target appears after HIT_SHOW.
- With `GAME_WRONG_HIT_PENALTY_EN`:
  - score=0, wrong box: score stays 0.
  - After one hit, wrong box then release: score 1→0.
  - Without the macro, score stays 1.
- Score saturation: force 255 hits (0 between strikes). `score`=255 and holds on a further hit.
- Assert `reset` during HIT_SHOW: next cycle IDLE, `play_sound`=0, `score`=0, `time_left`=GAME_SECONDS.
